gate_response_checker: RTL and testbench



---
 rtl/gate_response_checker.sv | 208 ++++++++++++++++++++
 tb/tb_gate_response_checker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// Response-side checker for a 2-input gate: compares c against the golden function of the selected
// gate over NUM_VEC valid samples. Optional first-fail capture under GATE_CHECKER_FIRST_FAIL_EN.
module gate_response_checker #(
  parameter int NUM_VEC = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       gate_sel,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  ,
  output logic [CNT_W-1:0] fail_idx,
  output logic [2:0]       fail_abc,
  output logic             fail_vld
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC);

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       cov_q, cov_d;
  logic             pass_q, pass_d;
  logic             mismatch_q, mismatch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             expected;
  logic             bad_sample;
  logic [CNT_W-1:0] vec_cnt_inc;
  logic [CNT_W-1:0] err_cnt_inc;
  logic [3:0]       cov_upd;

`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic [CNT_W-1:0] fail_idx_q, fail_idx_d;
  logic [2:0]       fail_abc_q, fail_abc_d;
  logic             fail_vld_q, fail_vld_d;
`endif

  function automatic logic golden(input logic [2:0] sel, input logic ga, input logic gb);
    logic r;
    case (sel)
      3'd0:    r = ga & gb;
      3'd1:    r = ga | gb;
      3'd2:    r = ~(ga & gb);
      3'd3:    r = ~(ga | gb);
      3'd4:    r = ga ^ gb;
      3'd5:    r = ~(ga ^ gb);
      3'd6:    r = ~ga;
      default: r = ga;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Per-sample evaluation against the gate type latched at start.
  always_comb begin
    expected    = golden(sel_q, a, b);
    bad_sample  = (c != expected);
    vec_cnt_inc = vec_cnt_q + 1'b1;
    err_cnt_inc = bad_sample ? sat_inc(err_cnt_q) : err_cnt_q;
    cov_upd     = cov_q | (4'b0001 << {a, b});
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    cov_d      = cov_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = done_q;
    mismatch_d = 1'b0;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    fail_idx_d = fail_idx_q;
    fail_abc_d = fail_abc_q;
    fail_vld_d = fail_vld_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          sel_d     = gate_sel;
          vec_cnt_d = '0;
          err_cnt_d = '0;
          cov_d     = '0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
          fail_idx_d = '0;
          fail_abc_d = '0;
          fail_vld_d = 1'b0;
`endif
        end
      end
      S_RUN: begin
        // Abort beats a coincident sample; counters are kept for post-mortem inspection.
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (in_valid) begin
          vec_cnt_d  = vec_cnt_inc;
          err_cnt_d  = err_cnt_inc;
          cov_d      = cov_upd;
          mismatch_d = bad_sample;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
          if (bad_sample && !fail_vld_q) begin
            fail_idx_d = vec_cnt_q;
            fail_abc_d = {a, b, c};
            fail_vld_d = 1'b1;
          end
`endif
          if (vec_cnt_inc == LAST_CNT) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_inc == '0) && (cov_upd == 4'hF);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      cov_q      <= '0;
      pass_q     <= 1'b0;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      cov_q      <= cov_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef GATE_CHECKER_FIRST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_idx_q <= '0;
      fail_abc_q <= '0;
      fail_vld_q <= 1'b0;
    end else begin
      fail_idx_q <= fail_idx_d;
      fail_abc_q <= fail_abc_d;
      fail_vld_q <= fail_vld_d;
    end
  end

  assign fail_idx = fail_idx_q;
  assign fail_abc = fail_abc_q;
  assign fail_vld = fail_vld_q;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign mismatch = mismatch_q;
  assign vec_cnt  = vec_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign cov      = cov_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized bench for gate_response_checker: two instances (NUM_VEC=4/CNT_W=8 and NUM_VEC=3/CNT_W=2)
// share stimulus and are compared every cycle against a truth-table reference model.
module tb_gate_response_checker;
  localparam int NV1 = 4;
  localparam int CW1 = 8;
  localparam int NV2 = 3;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic [2:0] gate_sel = 3'd0;

  logic busy1, done1, pass1, mm1;
  logic [CW1-1:0] vec1, err1;
  logic [3:0] cov1;
  logic busy2, done2, pass2, mm2;
  logic [CW2-1:0] vec2, err2;
  logic [3:0] cov2;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic [CW1-1:0] fidx1;
  logic [2:0] fabc1;
  logic fvld1;
  logic [CW2-1:0] fidx2;
  logic [2:0] fabc2;
  logic fvld2;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gate_response_checker #(.NUM_VEC(NV1), .CNT_W(CW1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_sel(gate_sel),
    .in_valid(in_valid), .a(a), .b(b), .c(c),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch(mm1),
    .vec_cnt(vec1), .err_cnt(err1), .cov(cov1)
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    , .fail_idx(fidx1), .fail_abc(fabc1), .fail_vld(fvld1)
`endif
  );

  gate_response_checker #(.NUM_VEC(NV2), .CNT_W(CW2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_sel(gate_sel),
    .in_valid(in_valid), .a(a), .b(b), .c(c),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch(mm2),
    .vec_cnt(vec2), .err_cnt(err2), .cov(cov2)
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    , .fail_idx(fidx2), .fail_abc(fabc2), .fail_vld(fvld2)
`endif
  );

  // Truth tables indexed by {a,b}: AND OR NAND NOR XOR XNOR NOTa BUFa
  logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                         4'b0110, 4'b1001, 4'b0011, 4'b1100};

  // st: 0 idle, 1 run, 2 done
  typedef struct {
    int         st;
    int         sel;
    int         vc;
    int         ec;
    logic [3:0] cov;
    bit         pass;
    bit         mm;
    int         fidx;
    logic [2:0] fabc;
    bit         fvld;
  } mdl_t;

  function automatic mdl_t reset_m();
    mdl_t r;
    r.st = 0; r.sel = 0; r.vc = 0; r.ec = 0; r.cov = 4'h0;
    r.pass = 1'b0; r.mm = 1'b0; r.fidx = 0; r.fabc = 3'b000; r.fvld = 1'b0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, int nv, int emax);
    mdl_t n;
    int ab;
    logic e;
    n = m;
    n.mm = 1'b0;
    ab = int'({a, b});
    if (m.st == 1) begin
      if (abort) begin
        n.st = 0;
        n.pass = 1'b0;
      end else if (in_valid) begin
        e = TT[m.sel][ab];
        n.vc = m.vc + 1;
        n.cov = m.cov | (4'b0001 << ab);
        if (c !== e) begin
          n.mm = 1'b1;
          n.ec = (m.ec < emax) ? m.ec + 1 : emax;
          if (!m.fvld) begin
            n.fvld = 1'b1;
            n.fidx = m.vc;
            n.fabc = {a, b, c};
          end
        end
        if (n.vc == nv) begin
          n.st = 2;
          n.pass = (n.ec == 0) && (n.cov == 4'hF);
        end
      end
    end else if (start) begin
      n = reset_m();
      n.st = 1;
      n.sel = int'(gate_sel);
    end
    return n;
  endfunction

  mdl_t m1 = reset_m();
  mdl_t m2 = reset_m();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= reset_m();
      m2 <= reset_m();
    end else begin
      m1 <= step(m1, NV1, (1 << CW1) - 1);
      m2 <= step(m2, NV2, (1 << CW2) - 1);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp_m(input string tag, input mdl_t m, input logic bz, input logic dn,
                       input logic ps, input logic mm, input int vc, input int ec,
                       input logic [3:0] cv);
    chk({tag, ".busy"}, int'(bz), int'(m.st == 1));
    chk({tag, ".done"}, int'(dn), int'(m.st == 2));
    chk({tag, ".pass"}, int'(ps), int'(m.pass));
    chk({tag, ".mismatch"}, int'(mm), int'(m.mm));
    chk({tag, ".vec_cnt"}, vc, m.vc);
    chk({tag, ".err_cnt"}, ec, m.ec);
    chk({tag, ".cov"}, int'(cv), int'(m.cov));
  endtask

  always @(negedge clk) begin
    cmp_m("d1", m1, busy1, done1, pass1, mm1, int'(vec1), int'(err1), cov1);
    cmp_m("d2", m2, busy2, done2, pass2, mm2, int'(vec2), int'(err2), cov2);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    chk("d1.fail_vld", int'(fvld1), int'(m1.fvld));
    chk("d1.fail_idx", int'(fidx1), m1.fidx);
    chk("d1.fail_abc", int'(fabc1), int'(m1.fabc));
    chk("d2.fail_vld", int'(fvld2), int'(m2.fvld));
    chk("d2.fail_idx", int'(fidx2), m2.fidx);
    chk("d2.fail_abc", int'(fabc2), int'(m2.fabc));
`endif
  end

  task automatic cyc(input bit st, input bit ab, input bit iv, input bit ia, input bit ib,
                     input bit ic, input logic [2:0] sel);
    start = st; abort = ab; in_valid = iv; a = ia; b = ib; c = ic; gate_sel = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input bit ia, input bit ib, input bit ic);
    cyc(1'b0, 1'b0, 1'b1, ia, ib, ic, gate_sel);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, gate_sel);
  endtask

  initial begin
    bit st, ab, iv, ia, ib, ic;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", int'(busy1), 0);
    chk("rst.vec_cnt", int'(vec1), 0);
    chk("rst.cov", int'(cov1), 0);
    rst = 1'b0;
    idle();

    // XNOR, all four combinations correct
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
    chk("s1.busy", int'(busy1), 1);
    smp(0, 0, 1); smp(0, 1, 0); smp(1, 0, 0);
    chk("s1.d2_done", int'(done2), 1);
    chk("s1.d2_cov", int'(cov2), 7);
    chk("s1.d2_pass", int'(pass2), 0);
    chk("s1.done_early", int'(done1), 0);
    smp(1, 1, 1);
    chk("s1.done", int'(done1), 1);
    chk("s1.pass", int'(pass1), 1);
    chk("s1.err", int'(err1), 0);
    chk("s1.cov", int'(cov1), 15);
    chk("s1.vec", int'(vec1), 4);
    idle();

    // XNOR with one wrong sample
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
    smp(0, 0, 1);
    chk("s2.mm_before", int'(mm1), 0);
    smp(0, 1, 1);
    chk("s2.mm", int'(mm1), 1);
    chk("s2.err", int'(err1), 1);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    chk("s2.fail_idx", int'(fidx1), 1);
    chk("s2.fail_abc", int'(fabc1), 3);
`endif
    smp(1, 0, 0);
    chk("s2.mm_after", int'(mm1), 0);
    smp(1, 1, 1);
    chk("s2.done", int'(done1), 1);
    chk("s2.pass", int'(pass1), 0);
    chk("s2.err_final", int'(err1), 1);

    // AND, correct results but incomplete coverage
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    smp(0, 0, 0); smp(0, 0, 0); smp(1, 1, 1); smp(1, 1, 1);
    chk("s3.cov", int'(cov1), 9);
    chk("s3.err", int'(err1), 0);
    chk("s3.done", int'(done1), 1);
    chk("s3.pass", int'(pass1), 0);

    // All samples wrong: small-counter instance ends at 3 and holds
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    smp(0, 0, 1); smp(0, 1, 1); smp(1, 0, 1);
    chk("s4.d2_err", int'(err2), 3);
    chk("s4.d2_done", int'(done2), 1);
    smp(1, 1, 0);
    idle(); idle();
    chk("s4.d2_err_hold", int'(err2), 3);
    chk("s4.d1_err", int'(err1), 4);

    // Gaps, mid-run start with sel change, then abort
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    smp(0, 1, 1);
    idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    smp(0, 0, 0);
    idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    chk("s5.busy", int'(busy1), 0);
    chk("s5.done", int'(done1), 0);
    chk("s5.vec", int'(vec1), 2);
    chk("s5.err", int'(err1), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    chk("s5.restart_vec", int'(vec1), 0);
    chk("s5.restart_cov", int'(cov1), 0);
    chk("s5.restart_busy", int'(busy1), 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    chk("s5.abort_wins", int'(busy1), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    chk("s5.start_wins", int'(busy1), 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      st = ($urandom % 10) == 0;
      ab = ($urandom % 60) == 0;
      iv = ($urandom % 4) != 0;
      ia = $urandom % 2;
      ib = $urandom % 2;
      ic = TT[m1.sel][int'({ia, ib})] ^ (($urandom % 8) == 0);
      cyc(st, ab, iv, ia, ib, ic, 3'($urandom % 8));
    end

    // Asynchronous reset between clock edges during a run
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    smp(0, 1, 1); smp(1, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("s7.busy", int'(busy1), 0);
    chk("s7.vec", int'(vec1), 0);
    chk("s7.err", int'(err1), 0);
    chk("s7.cov", int'(cov1), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(); idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
